// File: rtl/dmem_responder.sv
// dmem_responder: word-addressed data memory answering the pipelined core's
// MEM-stage data port. Core loads are combinational and core stores commit on
// the rising edge. A three-state controller (RUN / LOAD / ZERO) adds a
// streaming valid/ready preload port and a hardware zero-fill so that boot
// logic or a bench can initialise the array without the core.
//
// Build option: define DMEM_STATS_EN to add the rd_count / wr_count access
// counters. With the macro undefined, those ports and counters are absent.
module dmem_responder #(
    parameter int DATA_SIZE = 32,
    parameter int ADDR_SIZE = 10
) (
    input  logic                 CLK,
    input  logic                 RESET_N,
    input  logic                 CLEAR,
    input  logic [ADDR_SIZE-1:0] daddr,
    input  logic [DATA_SIZE-1:0] ddata_w,
    input  logic                 mem_write,
    input  logic                 mem_read,
    output logic [DATA_SIZE-1:0] ddata_r,
    input  logic                 load_start,
    input  logic [ADDR_SIZE-1:0] load_base,
    input  logic                 zero_start,
    input  logic                 load_valid,
    input  logic [DATA_SIZE-1:0] load_data,
    input  logic                 load_last,
    output logic                 load_ready,
    output logic                 busy,
`ifdef DMEM_STATS_EN
    output logic [31:0]          rd_count,
    output logic [31:0]          wr_count,
`endif
    output logic [ADDR_SIZE:0]   load_count
);

    localparam int DEPTH = 1 << ADDR_SIZE;

    // load_count saturates at exactly DEPTH, which needs the extra MSB.
    localparam logic [ADDR_SIZE:0]   COUNT_MAX = {1'b1, {ADDR_SIZE{1'b0}}};
    localparam logic [ADDR_SIZE-1:0] PTR_LAST  = {ADDR_SIZE{1'b1}};

    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_LOAD = 2'd1,
        ST_ZERO = 2'd2
    } state_t;

    state_t               r_state;
    logic [ADDR_SIZE-1:0] r_ptr;
    logic [ADDR_SIZE:0]   r_load_count;
    logic                 r_load_ready;
    logic                 r_busy;

    // Storage array; contents are deliberately never reset.
    logic [DATA_SIZE-1:0] r_mem [DEPTH];

    logic                 w_in_run;
    logic                 w_core_we;
    logic                 w_load_beat;
    logic                 w_zero_we;
    logic                 w_mem_we;
    logic [ADDR_SIZE-1:0] w_mem_addr;
    logic [DATA_SIZE-1:0] w_mem_wdata;

    // Core port is live only in RUN; a flushed store (CLEAR) is dropped.
    assign w_in_run    = (r_state == ST_RUN);
    assign w_core_we   = w_in_run && mem_write && !CLEAR;

    // A restart request in LOAD wins over a beat presented in the same cycle,
    // so that beat is neither written nor counted.
    assign w_load_beat = r_load_ready && load_valid && !load_start;
    assign w_zero_we   = (r_state == ST_ZERO);

    // Writes are suppressed while reset is held, so nothing lands in the
    // array during an abort.
    assign w_mem_we    = RESET_N && (w_core_we || w_load_beat || w_zero_we);

    // Select the single write port's address and data from whichever agent owns the array.
    always_comb begin
        w_mem_addr  = daddr;
        w_mem_wdata = ddata_w;
        if (r_state == ST_LOAD) begin
            w_mem_addr  = r_ptr;
            w_mem_wdata = load_data;
        end else if (r_state == ST_ZERO) begin
            w_mem_addr  = r_ptr;
            w_mem_wdata = '0;
        end
    end

    // Single write port; the combinational read below sees the old word on a same-address write.
    always_ff @(posedge CLK) begin
        if (w_mem_we) begin
            r_mem[w_mem_addr] <= w_mem_wdata;
        end
    end

    // Core load data is combinational; reads outside RUN return zero.
    assign ddata_r = (w_in_run && mem_read) ? r_mem[daddr] : '0;

    // Control FSM: RUN, LOAD and ZERO, with registered load_ready and busy.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_state      <= ST_RUN;
            r_ptr        <= '0;
            r_load_count <= '0;
            r_load_ready <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            case (r_state)
                ST_RUN: begin
                    if (zero_start) begin
                        // Zero-fill has priority over a simultaneous preload request.
                        r_state      <= ST_ZERO;
                        r_ptr        <= '0;
                        r_busy       <= 1'b1;
                        r_load_ready <= 1'b0;
                    end else if (load_start) begin
                        r_state      <= ST_LOAD;
                        r_ptr        <= load_base;
                        r_load_count <= '0;
                        r_busy       <= 1'b1;
                        r_load_ready <= 1'b1;
                    end
                end

                ST_LOAD: begin
                    if (load_start) begin
                        r_ptr        <= load_base;
                        r_load_count <= '0;
                    end else if (load_valid) begin
                        r_ptr <= r_ptr + 1'b1;
                        if (r_load_count != COUNT_MAX) begin
                            r_load_count <= r_load_count + 1'b1;
                        end
                        if (load_last) begin
                            r_state      <= ST_RUN;
                            r_busy       <= 1'b0;
                            r_load_ready <= 1'b0;
                        end
                    end
                end

                ST_ZERO: begin
                    r_ptr <= r_ptr + 1'b1;
                    if (r_ptr == PTR_LAST) begin
                        r_state <= ST_RUN;
                        r_busy  <= 1'b0;
                    end
                end

                default: begin
                    r_state      <= ST_RUN;
                    r_busy       <= 1'b0;
                    r_load_ready <= 1'b0;
                end
            endcase
        end
    end

    assign load_ready = r_load_ready;
    assign busy       = r_busy;
    assign load_count = r_load_count;

`ifdef DMEM_STATS_EN
    localparam logic [31:0] STAT_MAX = 32'hFFFF_FFFF;

    logic [31:0] r_rd_count;
    logic [31:0] r_wr_count;

    // Saturating access counters, counting only in RUN and cleared by an accepted zero-fill.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_rd_count <= '0;
            r_wr_count <= '0;
        end else if (w_in_run) begin
            if (zero_start) begin
                r_rd_count <= '0;
                r_wr_count <= '0;
            end else begin
                if (mem_read && (r_rd_count != STAT_MAX)) begin
                    r_rd_count <= r_rd_count + 1'b1;
                end
                if (w_core_we && (r_wr_count != STAT_MAX)) begin
                    r_wr_count <= r_wr_count + 1'b1;
                end
            end
        end
    end

    assign rd_count = r_rd_count;
    assign wr_count = r_wr_count;
`endif

endmodule

// File: doc/dmem_responder.md
# dmem_responder

Word-addressed data memory that answers the pipelined core's data port (`daddr`, `ddata_w`, `mem_write`, `mem_read` → `ddata_r`), the responder end of the core's MEM-stage interface. Core reads are combinational so `ddata_r` is valid in the same cycle the core latches it into MEM/WB; core writes commit on the rising edge. A small FSM adds a streaming preload port (valid/ready) and a hardware zero-fill, so benches and boot logic can initialise memory without the core.

## Interface
- `DATA_SIZE`, 32, word width in bits
- `ADDR_SIZE`, 10, word-address width; depth = 2^ADDR_SIZE words
- `CLK` in 1: single clock, rising edge
- `RESET_N` in 1: asynchronous, active-low reset
- `CLEAR` in 1: core pipeline flush; when high, the core write in that cycle is dropped
- `daddr` in ADDR_SIZE: core word address
- `ddata_w` in DATA_SIZE: core store data
- `mem_write` in 1: core store request
- `mem_read` in 1: core load request
- `ddata_r` out DATA_SIZE: core load data, combinational
- `load_start` in 1: single-cycle pulse; enter LOAD at `load_base`
- `load_base` in ADDR_SIZE: first preload word address, sampled with `load_start`
- `zero_start` in 1: single-cycle pulse; enter ZERO
- `load_valid` in 1, `load_data` in DATA_SIZE, `load_last` in 1: preload beat
- `load_ready` out 1: high only in LOAD
- `busy` out 1: high in LOAD or ZERO
- `load_count` out ADDR_SIZE+1: beats accepted since the last `load_start`

## Operation
- States: RUN (reset state), LOAD, ZERO. Pointer `ptr` is ADDR_SIZE bits wide.
- RUN: `ddata_r = mem_read ? mem[daddr] : 0`. On an edge with `mem_write && !CLEAR`, the block writes `mem[daddr] <= ddata_w`.
- Priority in RUN: `zero_start` over `load_start`. `zero_start` → ZERO, `ptr <= 0`. `load_start` → LOAD, `ptr <= load_base`, `load_count <= 0`.
- LOAD: each edge with `load_valid && load_ready` writes `mem[ptr] <= load_data`, increments `ptr` (mod 2^ADDR_SIZE, wraps to 0), and increments `load_count` (saturates at 2^ADDR_SIZE).
  - If that beat has `load_last`, the next state is RUN.
  - `load_start` in LOAD restarts at the new `load_base` with count 0; a beat in the same cycle is discarded.
  - `zero_start` is ignored in LOAD.
- ZERO: each cycle writes `mem[ptr] <= 0` and increments `ptr`. After writing index 2^ADDR_SIZE-1, the next state is RUN. Both start inputs are ignored in ZERO.
- Core accesses in LOAD or ZERO: writes are dropped and `ddata_r = 0`. The core is expected to be held in `CLEAR` during that time.
- Read and write to the same address in the same cycle: `ddata_r` returns the old contents (read-before-write). The new value is visible from the next cycle.
- Memory contents are not reset. `RESET_N` low mid-LOAD or mid-ZERO aborts to RUN; words already written keep their values.

## Timing
- Reset values: state RUN, `ptr` 0, `load_count` 0, `load_ready` 0, `busy` 0. `ddata_r` is 0 while `mem_read` is low.
- Read latency 0 cycles: combinational from `daddr`/`mem_read`. Write latency 1 edge.
- `load_start` sampled at edge N → `load_ready`/`busy` high from cycle N+1.
- Last beat accepted at edge M → `load_ready`/`busy` low and core access enabled from cycle M+1.
- ZERO entered at edge N → `busy` high for exactly 2^ADDR_SIZE cycles → RUN.
- `load_ready` does not depend combinationally on `load_valid`.

## Configuration
- `DMEM_STATS_EN` defined: adds outputs `rd_count` and `wr_count`, each 32 bits, reset 0, saturating at 2^32-1.
  - `rd_count` increments on each edge with `mem_read` in RUN.
  - `wr_count` increments on each edge with `mem_write && !CLEAR` in RUN.
  - Both clear to 0 on an accepted `zero_start`.
- `DMEM_STATS_EN` undefined: the ports and counters are absent, and all other behaviour is identical.

## Test plan
- Preload at `load_base`=0x3FE with 4 beats 0xA0..0xA3, `load_last` on the 4th, then read addresses 0x3FE, 0x3FF, 0x000, 0x001 → 0xA0, 0xA1, 0xA2, 0xA3 (wrap); `load_count` = 4; `load_ready` low the cycle after the last beat.
- RUN, `mem_write` 0x12345678 to addr 5 while `mem_read` addr 5 in the same cycle → `ddata_r` old value that cycle, 0x12345678 next cycle; repeat with `CLEAR`=1 → value unchanged.
- `zero_start` after filling memory with 0xFFFFFFFF → `busy` high exactly 1024 cycles, then reads of 0, 511, 1023 → 0.
- `load_start` and `zero_start` in the same cycle → ZERO entered, `load_ready` stays 0; core write during ZERO to addr 7 → dropped, addr 7 reads 0 afterwards.
- Assert `RESET_N` low for one cycle after 2 of 5 LOAD beats → `busy`/`load_ready`/`load_count` return to 0; the 2 loaded words retain their data.
- With `DMEM_STATS_EN`: 3 reads, 2 writes, 1 write with `CLEAR` → `rd_count`=3, `wr_count`=2; after `zero_start` → both 0.
